// File: rtl/memctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: access lengths, FSM states, port select
// and the latched request record.
package memctrl_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b11;

    typedef enum logic [1:0] {
        MC_IDLE = 2'b00,
        MC_BUSY = 2'b01,
        MC_COOL = 2'b10
    } mc_state_e;

    typedef enum logic {
        MC_PORT_IF  = 1'b0,
        MC_PORT_MEM = 1'b1
    } mc_port_e;

    typedef struct packed {
        mc_port_e    port;
        logic        wr;
        logic [2:0]  nbytes;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mc_req_t;

    function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 3'd1;
            LEN_HALF: return 3'd2;
            LEN_WORD: return 3'd4;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/memctrl.sv
// Arbitrates IF/MEM onto an 8-bit RAM; store done N edges after accept, load done N+1 edges after.
// Requesters hold req until done; a COOL cycle after each access gives them time to drop it.
module memctrl
    import memctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_wr,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    input  logic [BYTE_W-1:0] ram_din,
    output logic [BYTE_W-1:0] ram_dout,
    output logic [31:0]       ram_a,
    output logic              ram_wr
);

    mc_state_e          r_state, w_state_nxt;
    logic [2:0]         r_cnt, w_cnt_nxt;
    mc_req_t            r_req, w_req_nxt;
    logic [31:0]        r_buf, w_buf_nxt;
    logic [31:0]        r_ram_a, w_ram_a_nxt;
    logic [BYTE_W-1:0]  r_ram_dout, w_ram_dout_nxt;
    logic               r_ram_wr, w_ram_wr_nxt;
    logic [31:0]        r_if_data, w_if_data_nxt;
    logic [31:0]        r_mem_rdata, w_mem_rdata_nxt;
    logic               r_if_done, w_if_done_nxt;
    logic               r_mem_done, w_mem_done_nxt;
    logic [2:0]         w_cnt_inc, w_cnt_dec;

    assign w_cnt_inc = r_cnt + 3'd1;
    assign w_cnt_dec = r_cnt - 3'd1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= MC_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_req_nxt       = r_req;
        w_buf_nxt       = r_buf;
        w_ram_a_nxt     = r_ram_a;
        w_ram_dout_nxt  = r_ram_dout;
        w_ram_wr_nxt    = 1'b0;
        w_if_data_nxt   = r_if_data;
        w_mem_rdata_nxt = r_mem_rdata;
        w_if_done_nxt   = 1'b0;
        w_mem_done_nxt  = 1'b0;
        case (r_state)
            MC_IDLE: begin
                // MEM holds the older instruction, so it wins a tie
                if (mem_req || if_req) begin
                    w_req_nxt.port   = mem_req ? MC_PORT_MEM : MC_PORT_IF;
                    w_req_nxt.wr     = mem_req & mem_wr;
                    w_req_nxt.nbytes = mem_req ? len_to_bytes(mem_len) : 3'd4;
                    w_req_nxt.addr   = mem_req ? mem_addr : if_addr;
                    w_req_nxt.wdata  = mem_wdata;
                    w_ram_a_nxt      = w_req_nxt.addr;
                    if (w_req_nxt.wr) begin
                        w_ram_wr_nxt   = 1'b1;
                        w_ram_dout_nxt = mem_wdata[BYTE_W-1:0];
                    end
                    w_cnt_nxt   = 3'd0;
                    w_buf_nxt   = '0;
                    w_state_nxt = MC_BUSY;
                end
            end
            MC_BUSY: begin
                if (r_req.wr) begin
                    if (r_cnt == r_req.nbytes - 3'd1) begin
                        w_mem_done_nxt = 1'b1;
                        w_state_nxt    = MC_COOL;
                    end else begin
                        w_cnt_nxt      = w_cnt_inc;
                        w_ram_a_nxt    = r_req.addr + {29'd0, w_cnt_inc};
                        w_ram_dout_nxt = r_req.wdata[{w_cnt_inc, 3'b000} +: BYTE_W];
                        w_ram_wr_nxt   = 1'b1;
                    end
                end else begin
                    // Address issue runs one cycle ahead; capture trails the address by two edges
                    if (w_cnt_inc < r_req.nbytes)
                        w_ram_a_nxt = r_req.addr + {29'd0, w_cnt_inc};
                    if (r_cnt != 3'd0)
                        w_buf_nxt[{w_cnt_dec, 3'b000} +: BYTE_W] = ram_din;
                    if (r_cnt == r_req.nbytes) begin
                        if (r_req.port == MC_PORT_MEM) begin
                            w_mem_done_nxt  = 1'b1;
                            w_mem_rdata_nxt = w_buf_nxt;
                        end else begin
                            w_if_done_nxt = 1'b1;
                            w_if_data_nxt = w_buf_nxt;
                        end
                        w_state_nxt = MC_COOL;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            MC_COOL: w_state_nxt = MC_IDLE;
            default: w_state_nxt = MC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_req       <= '0;
            r_buf       <= '0;
            r_ram_a     <= '0;
            r_ram_dout  <= '0;
            r_ram_wr    <= 1'b0;
            r_if_data   <= '0;
            r_mem_rdata <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_req       <= w_req_nxt;
            r_buf       <= w_buf_nxt;
            r_ram_a     <= w_ram_a_nxt;
            r_ram_dout  <= w_ram_dout_nxt;
            r_ram_wr    <= w_ram_wr_nxt;
            r_if_data   <= w_if_data_nxt;
            r_mem_rdata <= w_mem_rdata_nxt;
            r_if_done   <= w_if_done_nxt;
            r_mem_done  <= w_mem_done_nxt;
        end
    end

    assign if_data   = r_if_data;
    assign if_done   = r_if_done;
    assign mem_rdata = r_mem_rdata;
    assign mem_done  = r_mem_done;
    assign ram_a     = r_ram_a;
    assign ram_dout  = r_ram_dout;
    assign ram_wr    = r_ram_wr;

endmodule

// File: tb/tb_memctrl.sv
// Bench for memctrl: byte RAM model plus a golden byte map; each access is checked for data,
// done latency, pulse width, write count and arbitration order.
module tb_memctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_wr;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [1:0]  mem_len;
    logic [31:0] if_data, mem_rdata, ram_a;
    logic        if_done, mem_done, ram_wr;
    logic [7:0]  ram_din, ram_dout;

    always #5 clk = ~clk;

    memctrl u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
    );

    logic [7:0] ram_mem [logic [31:0]];
    logic [7:0] gold    [logic [31:0]];
    int wr_cnt = 0;
    int n_tests = 0;
    int n_fail = 0;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
    endfunction

    function automatic logic [7:0] gold_rd(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : dflt(a);
    endfunction

    // Synchronous byte RAM: read data appears the cycle after the address is sampled
    always @(posedge clk) begin
        ram_din <= ram_rd(ram_a);
        if (ram_wr === 1'b1) begin
            ram_mem[ram_a] = ram_dout;
            wr_cnt++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] addr, input int n);
        logic [31:0] r = 0;
        for (int k = 0; k < n; k++) r = r | (32'(gold_rd(addr + 32'(k))) << (8 * k));
        return r;
    endfunction

    task automatic gold_store(input logic [31:0] addr, input int n, input logic [31:0] wdata);
        for (int k = 0; k < n; k++) gold[addr + 32'(k)] = wdata[8*k +: 8];
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram_mem[a] = b;
        gold[a]    = b;
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
        return 32'h1000 + 32'($urandom_range(0, 255));
    endfunction

    function automatic logic [1:0] rand_len();
        int s = $urandom_range(0, 2);
        return (s == 0) ? 2'b00 : (s == 1) ? 2'b01 : 2'b11;
    endfunction

    // Single access from IDLE; returns in IDLE with both requests low
    task automatic do_access(input bit is_mem, input bit wr, input logic [1:0] len,
                             input logic [31:0] addr, input logic [31:0] wdata, input string tag);
        int n, lat_exp, lat, wr0, wrong;
        logic [31:0] exp_data, other0;
        n        = is_mem ? nbytes(len) : 4;
        lat_exp  = wr ? n : n + 1;
        exp_data = exp_load(addr, n);
        if (wr) gold_store(addr, n, wdata);
        other0 = is_mem ? if_data : mem_rdata;
        wr0    = wr_cnt;
        wrong  = 0;
        mem_req = is_mem; mem_wr = wr; mem_len = len; mem_addr = addr; mem_wdata = wdata;
        if_req = !is_mem; if_addr = addr;
        lat = -1;
        for (int e = 0; e < 20 && lat < 0; e++) begin
            @(negedge clk);
            if (is_mem ? mem_done : if_done) lat = e;
            else if (if_done || mem_done) wrong++;
        end
        check_val({tag, "_lat"}, lat, lat_exp);
        check_val({tag, "_wrong_done"}, wrong, 0);
        if (!wr) check_val({tag, "_data"}, is_mem ? mem_rdata : if_data, exp_data);
        check_val({tag, "_other_hold"}, is_mem ? if_data : mem_rdata, other0);
        check_val({tag, "_writes"}, wr_cnt - wr0, wr ? n : 0);
        mem_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
        check_val({tag, "_pulse"}, {31'd0, is_mem ? mem_done : if_done}, 0);
        if (!wr) check_val({tag, "_data_hold"}, is_mem ? mem_rdata : if_data, exp_data);
        check_val({tag, "_writes_cool"}, wr_cnt - wr0, wr ? n : 0);
        if (wr)
            for (int k = 0; k < n; k++)
                check_val({tag, "_ram"}, ram_rd(addr + 32'(k)), gold_rd(addr + 32'(k)));
        @(negedge clk);
    endtask

    // Both requests raised together: MEM first, IF accepted after MEM's COOL cycle
    task automatic arb(input bit wr, input logic [1:0] len, input logic [31:0] maddr,
                       input logic [31:0] wdata, input logic [31:0] iaddr, input string tag);
        int nm, lm, lat_m, lat_i;
        logic [31:0] exp_m, exp_i;
        nm = nbytes(len);
        lm = wr ? nm : nm + 1;
        exp_m = exp_load(maddr, nm);
        if (wr) gold_store(maddr, nm, wdata);
        exp_i = exp_load(iaddr, 4);
        mem_req = 1'b1; mem_wr = wr; mem_len = len; mem_addr = maddr; mem_wdata = wdata;
        if_req = 1'b1; if_addr = iaddr;
        lat_m = -1; lat_i = -1;
        for (int e = 0; e < 40 && lat_i < 0; e++) begin
            @(negedge clk);
            if (mem_done && lat_m < 0) begin
                lat_m = e;
                if (!wr) check_val({tag, "_mdata"}, mem_rdata, exp_m);
                mem_req = 1'b0;
            end
            if (if_done) begin
                lat_i = e;
                check_val({tag, "_idata"}, if_data, exp_i);
                if_req = 1'b0;
            end
        end
        mem_req = 1'b0; if_req = 1'b0;
        check_val({tag, "_mlat"}, lat_m, lm);
        check_val({tag, "_ilat"}, lat_i, lm + 2 + 5);
        @(negedge clk);
        @(negedge clk);
    endtask

    // SB with req held through done: the same store repeats 3 edges after the first accept
    task automatic held_sb(input logic [31:0] addr, input logic [7:0] b);
        logic [5:0] wr_pat, done_pat;
        wr_pat = '0; done_pat = '0;
        gold[addr] = b;
        mem_req = 1'b1; mem_wr = 1'b1; mem_len = 2'b00; mem_addr = addr; mem_wdata = {24'h0, b};
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            wr_pat[e]   = ram_wr;
            done_pat[e] = mem_done;
            if (e == 4) mem_req = 1'b0;
        end
        check_val("held_sb_wr_pattern", {26'd0, wr_pat}, 32'b001001);
        check_val("held_sb_done_pattern", {26'd0, done_pat}, 32'b010010);
        check_val("held_sb_ram", ram_rd(addr), b);
    endtask

    initial begin
        int mism, done_seen, wr_seen;
        logic [31:0] a, w;
        rst = 1'b1; if_req = 0; mem_req = 0; mem_wr = 0; mem_len = 0;
        mem_addr = 0; mem_wdata = 0; if_addr = 0;
        repeat (3) @(negedge clk);
        check_val("rst_if_data", if_data, 0);
        check_val("rst_mem_rdata", mem_rdata, 0);
        check_val("rst_ram_a", ram_a, 0);
        check_val("rst_ram_dout", {24'd0, ram_dout}, 0);
        check_val("rst_ram_wr", {31'd0, ram_wr}, 0);
        check_val("rst_if_done", {31'd0, if_done}, 0);
        check_val("rst_mem_done", {31'd0, mem_done}, 0);
        rst = 1'b0;
        @(negedge clk);

        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h10); preload(32'h103, 8'h00);
        do_access(0, 0, 2'b11, 32'h100, 0, "if_fetch");
        check_val("if_word", if_data, 32'h00100513);

        do_access(1, 1, 2'b11, 32'h20, 32'hDEADBEEF, "sw");
        check_val("sw_b0", ram_rd(32'h20), 8'hEF);
        check_val("sw_b1", ram_rd(32'h21), 8'hBE);
        check_val("sw_b2", ram_rd(32'h22), 8'hAD);
        check_val("sw_b3", ram_rd(32'h23), 8'hDE);

        preload(32'h30, 8'h80);
        arb(0, 2'b00, 32'h30, 0, 32'h100, "arb_lb");
        check_val("arb_lb_word", mem_rdata, 32'h00000080);

        preload(32'h40, 8'h34); preload(32'h41, 8'h12);
        do_access(1, 0, 2'b01, 32'h40, 0, "lh");
        check_val("lh_word", mem_rdata, 32'h00001234);

        preload(32'hFFFFFFFE, 8'h11); preload(32'hFFFFFFFF, 8'h22);
        preload(32'h00000000, 8'h33); preload(32'h00000001, 8'h44);
        do_access(1, 0, 2'b11, 32'hFFFFFFFE, 0, "lw_wrap");
        check_val("lw_wrap_word", mem_rdata, 32'h44332211);

        held_sb(32'h50, 8'h5A);

        for (int i = 0; i < 40; i++) begin
            a = rand_addr();
            w = $urandom;
            case ($urandom_range(0, 3))
                0: do_access(0, 0, 2'b11, a, 0, "rnd_if");
                1: do_access(1, 0, rand_len(), a, 0, "rnd_ld");
                2: do_access(1, 1, rand_len(), a, w, "rnd_st");
                default: arb($urandom_range(0, 1) == 1, rand_len(), a, w, rand_addr(), "rnd_arb");
            endcase
        end

        gold_store(32'h2000, 2, 32'hCAFEF00D);
        mem_req = 1'b1; mem_wr = 1'b1; mem_len = 2'b11; mem_addr = 32'h2000; mem_wdata = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_req = 1'b0;
        check_val("rst_mid_ram_wr", {31'd0, ram_wr}, 0);
        check_val("rst_mid_done", {31'd0, mem_done}, 0);
        done_seen = 0; wr_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_done || if_done) done_seen++;
            if (ram_wr) wr_seen++;
        end
        check_val("rst_mid_no_done", done_seen, 0);
        check_val("rst_mid_no_write", wr_seen, 0);
        check_val("rst_mid_b0", ram_rd(32'h2000), 8'h0D);
        check_val("rst_mid_b1", ram_rd(32'h2001), 8'hF0);
        check_val("rst_mid_b2", ram_rd(32'h2002), dflt(32'h2002));
        check_val("rst_mid_b3", ram_rd(32'h2003), dflt(32'h2003));
        do_access(1, 0, 2'b11, 32'h2000, 0, "post_rst_lw");

        mism = 0;
        foreach (gold[k]) if (ram_rd(k) !== gold[k]) mism++;
        check_val("final_mem_entries", ram_mem.num(), gold.num());
        check_val("final_mem_content", mism, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1);
    end

endmodule

// File: doc/memctrl.md
# memctrl

Byte-serial memory controller between the pipeline and the 8-bit RAM port. It arbitrates between the instruction-fetch port (IF) and the data port (MEM). It sequences each 1-, 2- or 4-byte access as consecutive byte transfers and returns an assembled little-endian word with a one-cycle done pulse. Sign extension stays in the MEM stage; this block always returns zero-extended data.

## Interface
Parameters:
- none; length and state encodings come from defines.v

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  32  fetch byte address
- if_data  out  32  fetched word, valid while if_done is high, held afterwards
- if_done  out  1  one-cycle pulse; fetch complete
- mem_req  in  1  data request; held high until mem_done
- mem_wr  in  1  1 = store, 0 = load
- mem_len  in  2  `LenByte 2'b00, `LenHalf 2'b01, `LenWord 2'b11
- mem_addr  in  32  data byte address
- mem_wdata  in  32  store data; low mem_len bytes are used
- mem_rdata  out  32  load data, zero-extended, valid while mem_done is high, held afterwards
- mem_done  out  1  one-cycle pulse; data access complete
- ram_din  in  8  RAM read byte; valid the cycle after the RAM samples ram_a
- ram_dout  out  8  RAM write byte
- ram_a  out  32  RAM byte address
- ram_wr  out  1  1 = write ram_dout at ram_a on the next edge

## Operation
- All outputs are registered.
- Reset values: if_data, mem_rdata, ram_a, ram_dout are 0; ram_wr, if_done, mem_done are 0; state is IDLE; cnt is 0.
- States:
  - IDLE: samples requests. mem_req wins over if_req because the older instruction goes first. On accept, latch port, addr, len (IF is always a 4-byte read) and wr. Drive ram_a=addr. For a store, drive ram_wr=1 and ram_dout=wdata[7:0]. Set cnt=0 and go to BUSY.
  - BUSY, store: each edge increments cnt and drives ram_a=addr+cnt and ram_dout=wdata[8·cnt+:8]. After the last byte is written, clear ram_wr, pulse done and go to COOL.
  - BUSY, load: issue addresses addr+0..addr+N-1 on consecutive cycles. Byte k is captured from ram_din into data[8k+:8] two edges after its address was driven. Bytes above N are zero. After the last capture, pulse done and go to COOL.
  - COOL: done is high for this cycle only. Requests are ignored, which gives the requester one cycle to drop req. Go to IDLE.
- An access is never preempted. A pending if_req waits for the current MEM access, including its COOL cycle.
- Address arithmetic is 32-bit and wraps modulo 2^32 (0xFFFFFFFF+1 → 0x00000000).
- In IDLE and COOL: ram_wr=0; ram_a and ram_dout hold their last value.
- Done, data and port routing: only the served port's done and data outputs change; the other port's data output holds.

## Timing
- E0 is the edge at which the request is accepted in IDLE.
- Store of N bytes: byte k is on the bus after edge E_k, and the RAM writes it at E_{k+1}. Done is high in the cycle after E_N.
- Load of N bytes: address k is on the bus after E_k, and the byte is captured at E_{k+2}. Done is high in the cycle after E_{N+1}. Word load: done after E5; byte load: done after E2.
- Earliest next accept is the edge after the done cycle (COOL → IDLE). Next accept is therefore at E_{N+2} for stores and at E_{N+3} for loads.
- Both requests high in IDLE: MEM is accepted at E0. IF is accepted at the first IDLE edge after MEM's COOL cycle.
- rst high at any edge:
  - state returns to IDLE, ram_wr=0, done outputs 0, and cnt is cleared at that edge;
  - a partial store stays partial, with no further bytes written;
  - a partial load is discarded and no done is produced.
- A req still high during COOL is not re-accepted in COOL. If it is still high in IDLE, it is accepted as a new access.

## Structure
- defines.v holds:
  - length encodings `LenByte/`LenHalf/`LenWord;
  - state encodings `McIdle/`McBusy/`McCool (2 bits);
  - port select `McPortIf/`McPortMem;
  - `ByteBus [7:0].
- Single module, no sub-module: the byte sequencer and arbiter share one counter and one state register, and splitting them adds handshake cost without reuse.

## Test plan
- IF read at 0x100, RAM bytes 0x13,0x05,0x10,0x00 → if_data=0x00100513; if_done high exactly one cycle, after E5; ram_wr never high.
- MEM SW 0xDEADBEEF at 0x20 → RAM receives writes 0xEF@0x20, 0xBE@0x21, 0xAD@0x22, 0xDE@0x23 on consecutive edges; mem_done high after E4.
- if_req and mem_req rise together, MEM LB at 0x30 holding 0x80 → MEM served first with mem_rdata=0x00000080 and done after E2; IF accepted at E4.
- MEM LH at 0x40, bytes 0x34,0x12 → mem_rdata=0x00001234; MEM LW at 0xFFFFFFFE → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 issued in that order.
- rst asserted after two bytes of an SW → ram_wr=0 from the next cycle; 0x22 and 0x23 are unwritten; mem_done never pulses; state is IDLE.
- mem_req held high through mem_done → no accept in COOL; a new access starts at the following IDLE edge; back-to-back SB pair → second write begins exactly 3 edges after the first accept.
